// File: rtl/screen_blitter_pkg.sv
// Shared types and helpers for the full-screen blitter: FSM state encoding,
// default frame size and a clog2 variant that never yields a zero width.
package screen_blit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } blit_state_e;

  localparam int unsigned DEF_W = 160;
  localparam int unsigned DEF_H = 120;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/screen_blitter_delay_line.sv
// LAT-stage shift register carrying {valid, x, y} alongside the ROM read,
// so pixel coordinates reach the output stage together with their ROM data.
module blit_delay_line #(
  parameter int unsigned LAT = 1,
  parameter int unsigned XW  = 8,
  parameter int unsigned YW  = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [XW-1:0] in_x,
  input  logic [YW-1:0] in_y,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          any_valid
);

  logic [LAT-1:0] valid_q, valid_d;
  logic [XW-1:0]  x_q [LAT];
  logic [XW-1:0]  x_d [LAT];
  logic [YW-1:0]  y_q [LAT];
  logic [YW-1:0]  y_d [LAT];

  always_comb begin
    valid_d[0] = in_valid & ~flush;
    x_d[0]     = in_x;
    y_d[0]     = in_y;
    for (int unsigned i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1] & ~flush;
      x_d[i]     = x_q[i-1];
      y_d[i]     = y_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < LAT; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_x     = x_q[LAT-1];
  assign out_y     = y_q[LAT-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/screen_blitter.sv
// Full-screen raster blitter: scans a W x H frame issuing one ROM read per
// cycle and emits aligned plot/x/y/colour, with fill mode, abort and done pulse.
module screen_blitter
  import screen_blit_pkg::*;
#(
  parameter  int unsigned W         = DEF_W,
  parameter  int unsigned H         = DEF_H,
  parameter  int unsigned COLOUR_W  = 2,
  parameter  int unsigned N_SCREENS = 3,
  parameter  int unsigned ROM_LAT   = 1,
  localparam int unsigned XW        = clog2_min1(W),
  localparam int unsigned YW        = clog2_min1(H),
  localparam int unsigned AW        = clog2_min1(W * H),
  localparam int unsigned SW        = clog2_min1(N_SCREENS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          go,
  input  logic                          abort,
  input  logic                          fill,
  input  logic [SW-1:0]                 screen_select,
  input  logic [COLOUR_W-1:0]           fill_colour,
  output logic [AW-1:0]                 rom_addr,
  input  logic [N_SCREENS*COLOUR_W-1:0] rom_q,
  output logic                          plot,
  output logic [XW-1:0]                 x,
  output logic [YW-1:0]                 y,
  output logic [COLOUR_W-1:0]           colour,
  output logic                          busy,
  output logic                          done
);

  blit_state_e         state_q, state_d;
  logic [XW-1:0]       cx_q, cx_d, px_q, px_d;
  logic [YW-1:0]       cy_q, cy_d, py_q, py_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                fill_q, fill_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [COLOUR_W-1:0] fcol_q, fcol_d, colour_q, colour_d, pix_colour;
  logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic                push, flush, tail_valid, any_valid;
  logic [XW-1:0]       tail_x;
  logic [YW-1:0]       tail_y;

  assign flush = abort && (state_q != IDLE);

  blit_delay_line #(
    .LAT (ROM_LAT),
    .XW  (XW),
    .YW  (YW)
  ) u_delay (
    .clk       (clk),
    .rst_n     (resetn),
    .flush     (flush),
    .in_valid  (push),
    .in_x      (cx_q),
    .in_y      (cy_q),
    .out_valid (tail_valid),
    .out_x     (tail_x),
    .out_y     (tail_y),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    addr_d  = addr_q;
    fill_d  = fill_q;
    sel_d   = sel_q;
    fcol_d  = fcol_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          fill_d  = fill;
          sel_d   = screen_select;
          fcol_d  = fill_colour;
          cx_d    = '0;
          cy_d    = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          push = 1'b1;
          // Counters stop on the last pixel so rom_addr holds W*H-1 afterwards.
          if (addr_q == AW'(W * H - 1)) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
            if (cx_q == XW'(W - 1)) begin
              cx_d = '0;
              cy_d = cy_q + YW'(1);
            end else begin
              cx_d = cx_q + XW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!any_valid) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_colour = '0;
    if (fill_q) begin
      pix_colour = fcol_q;
    end else begin
      for (int unsigned i = 0; i < N_SCREENS; i++) begin
        if (sel_q == SW'(i)) pix_colour = rom_q[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  always_comb begin
    plot_d   = tail_valid & ~flush;
    px_d     = px_q;
    py_d     = py_q;
    colour_d = colour_q;
    if (plot_d) begin
      px_d     = tail_x;
      py_d     = tail_y;
      colour_d = pix_colour;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      addr_q   <= '0;
      fill_q   <= 1'b0;
      sel_q    <= '0;
      fcol_q   <= '0;
      plot_q   <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      colour_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      addr_q   <= addr_d;
      fill_q   <= fill_d;
      sel_q    <= sel_d;
      fcol_q   <= fcol_d;
      plot_q   <= plot_d;
      px_q     <= px_d;
      py_q     <= py_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign plot     = plot_q;
  assign x        = px_q;
  assign y        = py_q;
  assign colour   = colour_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_screen_blitter.sv
// Directed bench for screen_blitter on a 4x3 frame: one instance with ROM
// latency 1 and one with latency 3, each fed by a latency-matched ROM model.
module tb_screen_blitter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0, abort = 1'b0, fill = 1'b0;
  logic [1:0] screen_select = '0, fill_colour = '0;
  logic       use3 = 1'b0, rom_rand = 1'b0;
  int         checks = 0, errors = 0;

  logic       go1, go3;
  logic [3:0] addr1, addr3, a3_0, a3_1;
  logic [5:0] rq1, rq3;
  logic       plot1, plot3, busy1, busy3, done1, done3;
  logic [1:0] x1, x3, y1, y3, col1, col3;
  logic       plot_o, busy_o, done_o;
  logic [1:0] x_o, y_o, colour_o;

  always #5 clk = ~clk;

  assign go1 = go & ~use3;
  assign go3 = go & use3;

  screen_blitter #(.W(4), .H(3), .COLOUR_W(2), .N_SCREENS(3), .ROM_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .go(go1), .abort(abort), .fill(fill),
    .screen_select(screen_select), .fill_colour(fill_colour), .rom_addr(addr1),
    .rom_q(rq1), .plot(plot1), .x(x1), .y(y1), .colour(col1), .busy(busy1), .done(done1)
  );

  screen_blitter #(.W(4), .H(3), .COLOUR_W(2), .N_SCREENS(3), .ROM_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn), .go(go3), .abort(abort), .fill(fill),
    .screen_select(screen_select), .fill_colour(fill_colour), .rom_addr(addr3),
    .rom_q(rq3), .plot(plot3), .x(x3), .y(y3), .colour(col3), .busy(busy3), .done(done3)
  );

  // Screen 0 = 3, screen 1 = addr[1:0], screen 2 = addr[2:1]
  function automatic logic [5:0] mk(input logic [3:0] a);
    return {a[2:1], a[1:0], 2'b11};
  endfunction

  always @(posedge clk) begin
    rq1  <= rom_rand ? 6'($urandom) : mk(addr1);
    a3_0 <= addr3;
    a3_1 <= a3_0;
    rq3  <= rom_rand ? 6'($urandom) : mk(a3_1);
  end

  assign plot_o   = use3 ? plot3 : plot1;
  assign busy_o   = use3 ? busy3 : busy1;
  assign done_o   = use3 ? done3 : done1;
  assign x_o      = use3 ? x3 : x1;
  assign y_o      = use3 ? y3 : y1;
  assign colour_o = use3 ? col3 : col1;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] expcol(input logic fv, input logic [1:0] sv,
                                        input logic [1:0] fc, input int n);
    if (fv) return fc;
    case (sv)
      2'd0:    return 2'b11;
      2'd1:    return 2'(n);
      2'd2:    return 2'(n >> 1);
      default: return 2'b00;
    endcase
  endfunction

  // Pulses go, then checks every plot's content and cycle offset and the done cycle.
  task automatic run_frame(input string tag, input logic l3, input logic fv,
                           input logic [1:0] sv, input logic [1:0] fc, input bit midgo);
    int n, dcyc, lat;
    lat = l3 ? 3 : 1;
    use3 = l3;
    fill = fv;
    screen_select = sv;
    fill_colour = fc;
    go = 1'b1;
    step();
    go = 1'b0;
    fill = ~fv;
    screen_select = sv ^ 2'b01;
    fill_colour = ~fc;
    chk(tag, "busy_start", busy_o, 1);
    n = 0;
    dcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      go = (midgo && c == 6);
      if (plot_o) begin
        chk(tag, $sformatf("pix%0d", n), {busy_o, x_o, y_o, colour_o},
            {1'b1, 2'(n % 4), 2'(n / 4), expcol(fv, sv, fc, n)});
        chk(tag, $sformatf("pix%0d_cycle", n), c, 2 + n + lat);
        n++;
      end
      if (done_o) begin
        dcyc = c;
        chk(tag, "done_busy", busy_o, 0);
        break;
      end
      step();
    end
    go = 1'b0;
    chk(tag, "plot_count", n, 12);
    chk(tag, "done_cycle", dcyc, 14 + lat);
  endtask

  initial begin
    logic bad;
    step();
    step();
    chk("reset", "dut1_outs", {plot1, x1, y1, col1, busy1, done1, addr1}, 0);
    chk("reset", "dut3_outs", {plot3, x3, y3, col3, busy3, done3, addr3}, 0);
    resetn = 1'b1;
    step();

    run_frame("lat1_scr1", 1'b0, 1'b0, 2'd1, 2'b00, 1'b0);
    step();
    run_frame("lat3_scr1", 1'b1, 1'b0, 2'd1, 2'b00, 1'b0);
    step();
    run_frame("lat1_scr2", 1'b0, 1'b0, 2'd2, 2'b00, 1'b0);
    step();

    rom_rand = 1'b1;
    run_frame("fill", 1'b0, 1'b1, 2'd1, 2'b10, 1'b0);
    rom_rand = 1'b0;
    step();

    run_frame("midgo", 1'b0, 1'b0, 2'd1, 2'b00, 1'b1);
    step();

    // Abort while pixel 5 is on the outputs
    use3 = 1'b0;
    screen_select = 2'd1;
    fill = 1'b0;
    go = 1'b1;
    step();
    go = 1'b0;
    repeat (7) step();
    chk("abort", "pix5", {plot_o, x_o, y_o}, {1'b1, 2'd1, 2'd1});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort", "outs_after", {plot_o, busy_o, done_o}, 0);
    bad = 1'b0;
    repeat (20) begin
      step();
      bad |= plot_o | busy_o | done_o;
    end
    chk("abort", "quiet", bad, 0);
    run_frame("after_abort", 1'b0, 1'b0, 2'd1, 2'b00, 1'b0);
    step();

    // Asynchronous reset mid-cycle while pixel 7 is on the outputs
    go = 1'b1;
    step();
    go = 1'b0;
    repeat (9) step();
    chk("rst", "pix7", {plot_o, x_o, y_o}, {1'b1, 2'd3, 2'd1});
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst", "outs_async", {plot1, x1, y1, col1, busy1, done1, addr1}, 0);
    step();
    step();
    resetn = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      step();
      bad |= plot_o | busy_o | done_o;
    end
    chk("rst", "idle_after", bad, 0);
    run_frame("after_rst", 1'b0, 1'b0, 2'd1, 2'b00, 1'b0);
    step();

    run_frame("sel3", 1'b0, 1'b0, 2'd3, 2'b11, 1'b0);
    step();

    // Back-to-back: second go lands in the done cycle of the first
    run_frame("b2b_a", 1'b0, 1'b0, 2'd1, 2'b00, 1'b0);
    run_frame("b2b_b", 1'b0, 1'b0, 2'd1, 2'b00, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
